// File: rtl/screen_flusher.sv
// Frame scanner: walks every (x, y) of the screen, queries the renderers, and
// streams one registered pixel write per cycle to the VGA adapter.
module screen_flusher #(
    parameter int          WIDTH     = 160,
    parameter int          HEIGHT    = 120,
    parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] flush_x,
    output logic [7:0] flush_y,
    input  logic [5:0] sprite_colour,
    input  logic       sprite_enable,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST_X = 8'(WIDTH - 1);
    localparam logic [7:0] LAST_Y = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_flushX;
    logic [7:0] r_flushY;
    logic [7:0] w_nextX;
    logic [7:0] w_nextY;
    logic [7:0] r_vgaX;
    logic [7:0] r_vgaY;
    logic [5:0] r_vgaColour;
    logic       r_vgaPlot;

    // Coordinates return to (0,0) on the final wrap, so DRAIN/DONE/IDLE all present the origin.
    always_comb begin
        w_nextState = r_state;
        w_nextX     = r_flushX;
        w_nextY     = r_flushY;
        case (r_state)
            IDLE: begin
                w_nextX = 8'd0;
                w_nextY = 8'd0;
                if (start) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (r_flushX == LAST_X) begin
                    w_nextX = 8'd0;
                    if (r_flushY == LAST_Y) begin
                        w_nextY     = 8'd0;
                        w_nextState = DRAIN;
                    end else begin
                        w_nextY = r_flushY + 8'd1;
                    end
                end else begin
                    w_nextX = r_flushX + 8'd1;
                end
            end
            DRAIN:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_flushX    <= 8'd0;
            r_flushY    <= 8'd0;
            r_vgaX      <= 8'd0;
            r_vgaY      <= 8'd0;
            r_vgaColour <= 6'd0;
            r_vgaPlot   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_flushX <= w_nextX;
            r_flushY <= w_nextY;
            // One-cycle pixel pipeline; address/colour hold when not plotting.
            if (r_state == SCAN) begin
                r_vgaX      <= r_flushX;
                r_vgaY      <= r_flushY;
                r_vgaColour <= sprite_enable ? sprite_colour : BG_COLOUR;
                r_vgaPlot   <= 1'b1;
            end else begin
                r_vgaPlot   <= 1'b0;
            end
        end
    end

    assign flush_x    = r_flushX;
    assign flush_y    = r_flushY;
    assign vga_x      = r_vgaX;
    assign vga_y      = r_vgaY;
    assign vga_colour = r_vgaColour;
    assign vga_plot   = r_vgaPlot;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule
